// File: rtl/nios_system_sample_fetch_master.sv
// Burst read master: fetches word_count words from a 1-cycle-latency memory
// and streams them out in address order through a small flow-controlled FIFO.
module nios_system_sample_fetch_master #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   address,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_valid,
    input  logic                st_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cs_q, cs_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]    address_q, address_d;
    logic [ADDR_W:0]      rd_left_q, rd_left_d;
    logic [ADDR_W:0]      xfer_left_q, xfer_left_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];

    logic                 fifo_wr;
    logic                 xfer;
    logic [OCC_W-1:0]     occ;
    logic                 room;

    assign write      = 1'b0;
    assign byteenable = '1;
    assign clken      = 1'b1;
    assign busy       = busy_q;
    assign done       = done_q;
    assign chipselect = cs_q;
    assign address    = address_q;
    assign st_valid   = (count_q != '0);
    assign st_data    = mem_q[rd_ptr_q];

    // rd_pend_q marks the cycle in which a previously issued read returns.
    assign fifo_wr = rd_pend_q;
    assign xfer    = st_valid && st_ready;

    // chipselect is registered, so a read decided now lands two cycles later;
    // reserve space for both the returning read and the one already issued.
    assign occ  = OCC_W'(count_q) + OCC_W'(rd_pend_q) + OCC_W'(cs_q) - OCC_W'(xfer);
    assign room = occ < OCC_W'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cs_d        = 1'b0;
        rd_pend_d   = cs_q;
        address_d   = cs_q ? address_q + ADDR_W'(1) : address_q;
        rd_left_d   = rd_left_q;
        xfer_left_d = xfer ? xfer_left_q - (ADDR_W+1)'(1) : xfer_left_q;
        wr_ptr_d    = fifo_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = xfer ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({fifo_wr, xfer})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    address_d   = base_addr;
                    rd_left_d   = word_count;
                    xfer_left_d = word_count;
                    busy_d      = 1'b1;
                    state_d     = (word_count == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (rd_left_q != '0 && room) begin
                    cs_d      = 1'b1;
                    rd_left_d = rd_left_q - (ADDR_W+1)'(1);
                end
                if (cs_q && rd_left_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer_left_q == '0 && count_q == '0 && !rd_pend_q && !cs_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            address_q   <= '0;
            rd_left_q   <= '0;
            xfer_left_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            rd_pend_q   <= rd_pend_d;
            address_q   <= address_d;
            rd_left_q   <= rd_left_d;
            xfer_left_q <= xfer_left_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fifo_wr) begin
            mem_q[wr_ptr_q] <= readdata;
        end
    end

endmodule

// File: tb/tb_nios_system_sample_fetch_master.sv
// Directed bench for the sample fetch master: memory model returns word n = n,
// scoreboards check read addresses and streamed data in order.
module tb_nios_system_sample_fetch_master;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [ADDR_W:0]     word_count = '0;
    logic                busy, done, chipselect, write, clken, st_valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata = '0;
    logic [DATA_W-1:0]   st_data;
    logic                st_ready = 1'b1;

    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int run_len = 0;
    int last_rd_cyc = -10;

    nios_system_sample_fetch_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .address(address),
        .chipselect(chipselect), .write(write), .byteenable(byteenable),
        .clken(clken), .readdata(readdata), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        readdata <= chipselect ? DATA_W'(address) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect) begin
                rd_cnt++;
                run_len = (last_rd_cyc == cyc - 1) ? run_len + 1 : 1;
                last_rd_cyc = cyc;
                if (addr_q.size() == 0) chk("addr_extra", 32'(address), 32'hFFFF_FFFF);
                else chk("addr", 32'(address), 32'(addr_q.pop_front()));
            end
            if (st_valid) valid_cnt++;
            if (st_valid && st_ready) begin
                if (exp_q.size() == 0) chk("data_extra", st_data, 32'hFFFF_FFFF);
                else chk("data", st_data, exp_q.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] base, input int cnt);
        logic [ADDR_W-1:0] a;
        base_addr  = base;
        word_count = (ADDR_W+1)'(cnt);
        start      = 1'b1;
        a = base;
        for (int i = 0; i < cnt; i++) begin
            addr_q.push_back(a);
            exp_q.push_back(DATA_W'(a));
            a = a + ADDR_W'(1);
        end
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic run_until_done(input string tag, input int limit, input bit rnd, input bit poke);
        bit got = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (done) begin
                got = 1;
                break;
            end
            if (rnd) st_ready = 1'($urandom_range(0, 1));
            if (poke) begin
                start      = (i % 500 == 7);
                base_addr  = 14'h1234;
                word_count = 15'd3;
            end
        end
        start    = 1'b0;
        st_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(got), 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        step();
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
        chk({tag, "_addr_queue_empty"}, 32'(addr_q.size()), 0);
    endtask

    initial begin
        int rd0, v0;
        // reset state
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_valid", st_valid, 0);
        chk("rst_addr", 32'(address), 0);
        chk("tie_write", write, 0);
        chk("tie_be", 32'(byteenable), 32'hF);
        chk("tie_clken", clken, 1);
        reset = 1'b0;
        step();

        // basic burst
        rd0 = rd_cnt;
        start_burst(14'h0010, 8);
        run_until_done("basic", 200, 0, 0);
        chk("basic_reads", 32'(rd_cnt - rd0), 8);
        chk("basic_run_len", 32'(run_len), 8);

        // backpressure
        st_ready = 1'b0;
        rd0 = rd_cnt;
        start_burst(14'h0040, 16);
        repeat (10) step();
        chk("bp_reads", 32'(rd_cnt - rd0), DEPTH);
        chk("bp_cs_low", chipselect, 0);
        chk("bp_valid", st_valid, 1);
        chk("bp_head", st_data, 32'h40);
        st_ready = 1'b1;
        run_until_done("bp", 200, 0, 0);
        chk("bp_total_reads", 32'(rd_cnt - rd0), 16);

        // address wrap
        start_burst(14'h3FFE, 4);
        run_until_done("wrap", 200, 0, 0);

        // zero length
        rd0 = rd_cnt;
        v0  = valid_cnt;
        start_burst(14'h0100, 0);
        chk("zero_done_c1", done, 0);
        step();
        chk("zero_done_c2", done, 1);
        chk("zero_busy_c2", busy, 0);
        step();
        chk("zero_done_c3", done, 0);
        chk("zero_reads", 32'(rd_cnt - rd0), 0);
        chk("zero_valid", 32'(valid_cnt - v0), 0);

        // long burst, random ready, start pokes while busy
        start_burst(14'h0000, 16384);
        run_until_done("rand", 40000, 1, 1);

        // reset mid-burst
        start_burst(14'h0200, 32);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cs", chipselect, 0);
        chk("mid_rst_valid", st_valid, 0);
        chk("mid_rst_addr", 32'(address), 0);
        exp_q.delete();
        addr_q.delete();
        v0 = valid_cnt;
        repeat (3) step();
        chk("mid_rst_no_valid", 32'(valid_cnt - v0), 0);
        start_burst(14'h0300, 6);
        run_until_done("post_rst", 200, 0, 0);

        chk("done_pulses", 32'(done_cnt), 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
